// File: rtl/uart_pkt_parser.sv
// Frames a UART byte stream (SYNC, LEN, payload, CHK) and releases checked payloads on a valid/ready stream.
// Optional inter-byte timeout is built only when UART_PKT_TIMEOUT_EN is defined.
module uart_pkt_parser #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 1024,
  localparam int        W           = $clog2(MAX_LEN + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [W-1:0] pkt_len,
  output logic         busy,
  output logic         err_len,
  output logic         err_chk,
  output logic         err_ovr,
  output logic         err_to
);

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [W-1:0] ONE     = W'(1);

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("uart_pkt_parser: MAX_LEN must be 1..255 and TIMEOUT_CYC at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DRAIN
  } state_t;

  state_t       state_reg;
  logic [W-1:0] len_reg;
  logic [7:0]   chk_reg;
  logic [W-1:0] wr_ptr_reg;
  logic [W-1:0] rd_ptr_reg;
  logic [W-1:0] pkt_len_reg;
  logic [7:0]   out_data_reg;
  logic         out_valid_reg;
  logic         out_last_reg;
  logic         err_len_reg;
  logic         err_chk_reg;
  logic         err_ovr_reg;
  logic         to_expired;

  logic [7:0]   pay_mem [0:MAX_LEN-1];

  logic [W-1:0] rd_ptr_next;
  logic         len_bad;

  assign rd_ptr_next = rd_ptr_reg + ONE;
  assign len_bad     = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);

  // Payload store has no reset so it can map onto plain RAM/LUT storage.
  always_ff @(posedge clk) begin
    if (state_reg == ST_PAYLOAD && rx_valid) begin
      pay_mem[wr_ptr_reg[AW-1:0]] <= rx_data;
    end
  end

`ifdef UART_PKT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] idle_cnt_reg;
  logic          err_to_reg;
  logic          in_frame;

  assign in_frame   = (state_reg == ST_LEN) || (state_reg == ST_PAYLOAD) || (state_reg == ST_CHK);
  assign to_expired = in_frame && !rx_valid && (idle_cnt_reg == TO_LAST);

  // Saturates at TO_LAST; the FSM leaves the frame states on that same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt_reg <= '0;
      err_to_reg   <= 1'b0;
    end else begin
      err_to_reg <= to_expired;
      if (!in_frame || rx_valid) begin
        idle_cnt_reg <= '0;
      end else if (idle_cnt_reg != TO_LAST) begin
        idle_cnt_reg <= idle_cnt_reg + CW'(1);
      end
    end
  end

  assign err_to = err_to_reg;
`else
  assign to_expired = 1'b0;
  assign err_to     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      len_reg       <= '0;
      chk_reg       <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      pkt_len_reg   <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      err_len_reg   <= 1'b0;
      err_chk_reg   <= 1'b0;
      err_ovr_reg   <= 1'b0;
    end else begin
      err_len_reg <= 1'b0;
      err_chk_reg <= 1'b0;
      err_ovr_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state_reg <= ST_LEN;
          end
        end

        ST_LEN: begin
          if (rx_valid) begin
            if (len_bad) begin
              err_len_reg <= 1'b1;
              state_reg   <= ST_IDLE;
            end else begin
              len_reg    <= rx_data[W-1:0];
              chk_reg    <= rx_data;
              wr_ptr_reg <= '0;
              state_reg  <= ST_PAYLOAD;
            end
          end else if (to_expired) begin
            state_reg <= ST_IDLE;
          end
        end

        ST_PAYLOAD: begin
          if (rx_valid) begin
            chk_reg    <= chk_reg ^ rx_data;
            wr_ptr_reg <= wr_ptr_reg + ONE;
            if (wr_ptr_reg == len_reg - ONE) begin
              state_reg <= ST_CHK;
            end
          end else if (to_expired) begin
            state_reg <= ST_IDLE;
          end
        end

        // Any byte here is the checksum, including one equal to SYNC_BYTE.
        ST_CHK: begin
          if (rx_valid) begin
            if (rx_data == chk_reg) begin
              pkt_len_reg   <= len_reg;
              rd_ptr_reg    <= '0;
              out_valid_reg <= 1'b1;
              out_data_reg  <= pay_mem[0];
              out_last_reg  <= (len_reg == ONE);
              state_reg     <= ST_DRAIN;
            end else begin
              err_chk_reg <= 1'b1;
              state_reg   <= ST_IDLE;
            end
          end else if (to_expired) begin
            state_reg <= ST_IDLE;
          end
        end

        // Output registers only move on a handshake, so they hold under backpressure.
        ST_DRAIN: begin
          if (rx_valid) begin
            err_ovr_reg <= 1'b1;
          end
          if (out_ready) begin
            if (out_last_reg) begin
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
              state_reg     <= ST_IDLE;
            end else begin
              rd_ptr_reg   <= rd_ptr_next;
              out_data_reg <= pay_mem[rd_ptr_next[AW-1:0]];
              out_last_reg <= (rd_ptr_next == pkt_len_reg - ONE);
            end
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign pkt_len   = pkt_len_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign err_len   = err_len_reg;
  assign err_chk   = err_chk_reg;
  assign err_ovr   = err_ovr_reg;

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed self-checking bench for uart_pkt_parser (default parameters).
// Honours UART_PKT_TIMEOUT_EN to pick the matching timeout scenario.
module tb_uart_pkt_parser;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_last;
  logic [W-1:0] pkt_len;
  logic         busy;
  logic         err_len;
  logic         err_chk;
  logic         err_ovr;
  logic         err_to;

  always #5 clk = ~clk;

  uart_pkt_parser dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .pkt_len  (pkt_len),
    .busy     (busy),
    .err_len  (err_len),
    .err_chk  (err_chk),
    .err_ovr  (err_ovr),
    .err_to   (err_to)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] mon_data [256];
  logic       mon_last [256];
  int         mon_cyc  [256];
  int         mon_n = 0;
  int         n_len = 0;
  int         n_chk = 0;
  int         n_ovr = 0;
  int         n_to  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle monitor: records handshakes and counts error-pulse cycles.
  always @(negedge clk) begin
    if (out_valid && out_ready && mon_n < 256) begin
      mon_data[mon_n] = out_data;
      mon_last[mon_n] = out_last;
      mon_cyc[mon_n]  = cyc;
      mon_n = mon_n + 1;
      $display("out: data=%02h last=%0d pkt_len=%0d", out_data, out_last, pkt_len);
    end
    if (err_len) n_len = n_len + 1;
    if (err_chk) n_chk = n_chk + 1;
    if (err_ovr) n_ovr = n_ovr + 1;
    if (err_to)  n_to  = n_to + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("%s_idle", tag), int'(busy), 0);
  endtask

  task automatic check_pkt(input string tag, input int start, input logic [7:0] exp[$],
                           input bit consec);
    check($sformatf("%s_count", tag), mon_n - start, exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (start + i < mon_n) begin
        check($sformatf("%s_data%0d", tag, i), int'(mon_data[start+i]), int'(exp[i]));
        check($sformatf("%s_last%0d", tag, i), int'(mon_last[start+i]),
              (i == exp.size() - 1) ? 1 : 0);
        if (consec && i > 0) begin
          check($sformatf("%s_gap%0d", tag, i), mon_cyc[start+i] - mon_cyc[start+i-1], 1);
        end
      end
    end
  endtask

  initial begin
    logic [7:0] exp[$];
    int start;
    int b_len, b_chk, b_ovr, b_to;

    // Reset state
    idle(3);
    check("rst_outs", int'({out_valid, out_last, busy, err_len, err_chk, err_ovr, err_to}), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_pkt_len", int'(pkt_len), 0);
    reset = 1'b1;
    idle(2);

    // 1: basic packet, stray byte before SYNC
    $display("test1: 37 A5 03 11 22 33 03");
    out_ready = 1'b1;
    start = mon_n;
    b_len = n_len; b_chk = n_chk; b_ovr = n_ovr; b_to = n_to;
    send(8'h37);
    check("t1_ignore_busy", int'(busy), 0);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    check("t1_latency", int'(out_valid), 1);
    wait_idle("t1");
    exp = '{8'h11, 8'h22, 8'h33};
    check_pkt("t1", start, exp, 1'b1);
    check("t1_pkt_len", int'(pkt_len), 3);
    check("t1_errs", (n_len - b_len) + (n_chk - b_chk) + (n_ovr - b_ovr) + (n_to - b_to), 0);

    // 2: bad checksum then good single-byte packet
    $display("test2: A5 02 AA 55 00 / A5 01 7E 7F");
    start = mon_n;
    b_chk = n_chk;
    send(8'hA5); send(8'h02); send(8'hAA); send(8'h55); send(8'h00);
    idle(2);
    check("t2_err_chk", n_chk - b_chk, 1);
    check("t2_no_out", mon_n - start, 0);
    check("t2_busy", int'(busy), 0);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    wait_idle("t2b");
    exp = '{8'h7E};
    check_pkt("t2b", start, exp, 1'b0);

    // 3: length errors, then a full MAX_LEN packet
    $display("test3: A5 00 / A5 11 / A5 10 x16");
    b_len = n_len;
    send(8'hA5); send(8'h00);
    check("t3_busy0", int'(busy), 0);
    send(8'hA5); send(8'h11);
    check("t3_busy1", int'(busy), 0);
    idle(1);
    check("t3_err_len", n_len - b_len, 2);
    start = mon_n;
    exp.delete();
    send(8'hA5); send(8'h10);
    for (int i = 0; i < 16; i++) begin
      send(8'h40 + 8'(i));
      exp.push_back(8'h40 + 8'(i));
    end
    send(8'h10);
    wait_idle("t3");
    check_pkt("t3", start, exp, 1'b1);
    check("t3_pkt_len", int'(pkt_len), 16);

    // 4: backpressure and overrun
    $display("test4: A5 03 01 02 04 04 with stall");
    out_ready = 1'b0;
    start = mon_n;
    b_ovr = n_ovr;
    send(8'hA5); send(8'h03); send(8'h01); send(8'h02); send(8'h04); send(8'h04);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_hold_data%0d", i), int'(out_data), 8'h01);
      check($sformatf("t4_hold_vld%0d", i), int'({out_valid, out_last}), 2);
      if (i == 2) send(8'h99);
      else idle(1);
    end
    check("t4_err_ovr", n_ovr - b_ovr, 1);
    out_ready = 1'b1;
    wait_idle("t4");
    exp = '{8'h01, 8'h02, 8'h04};
    check_pkt("t4", start, exp, 1'b1);

`ifdef UART_PKT_TIMEOUT_EN
    // 5: partial packet abandoned by the inter-byte timeout
    $display("test5: A5 02 10 then silence (timeout)");
    b_to = n_to;
    send(8'hA5); send(8'h02); send(8'h10);
    idle(1000);
    check("t5_busy_before", int'(busy), 1);
    idle(30);
    check("t5_err_to", n_to - b_to, 1);
    check("t5_busy", int'(busy), 0);
`else
    // 5: partial packet waits through a long gap
    $display("test5: A5 02 10, 5000 idle, 20 32");
    start = mon_n;
    send(8'hA5); send(8'h02); send(8'h10);
    idle(5000);
    check("t5_busy_wait", int'(busy), 1);
    send(8'h20); send(8'h32);
    wait_idle("t5");
    exp = '{8'h10, 8'h20};
    check_pkt("t5", start, exp, 1'b1);
    check("t5_pkt_len", int'(pkt_len), 2);
`endif

    // 6: asynchronous reset in the middle of a payload
    $display("test6: reset mid-payload, then A5 01 5A 5B");
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_outs", int'({out_valid, out_last, busy, err_len, err_chk, err_ovr, err_to}), 0);
    check("t6_rst_len", int'(pkt_len), 0);
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    start = mon_n;
    send(8'hA5); send(8'h01); send(8'h5A); send(8'h5B);
    wait_idle("t6");
    exp = '{8'h5A};
    check_pkt("t6", start, exp, 1'b0);
    check("t6_pkt_len", int'(pkt_len), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_pkt_parser.md
Name: uart_pkt_parser

Overview:
Consumes the byte stream from the UART receiver as 8-bit data plus a 1-cycle valid strobe, and frames it into packets. Packet format is SYNC, LEN, LEN payload bytes, CHK. Payload is buffered internally and released to the command logic through a valid/ready stream only after the checksum passes. Bad packets are discarded and flagged with error pulses.

Parameters:
SYNC_BYTE  8'hA5  start-of-packet marker
MAX_LEN  16  maximum payload bytes (1..255); sets buffer depth
TIMEOUT_CYC  1024  inter-byte timeout in clk cycles (used only with the optional feature)

Ports:
clk  input  1  system clock, all logic on its rising edge
reset  input  1  asynchronous, active-low reset
rx_data  input  8  received byte, sampled only when rx_valid=1
rx_valid  input  1  1-cycle strobe per received byte
out_data  output  8  payload byte
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts byte when out_valid&&out_ready
out_last  output  1  marks the final payload byte of the packet
pkt_len  output  W=$clog2(MAX_LEN+1)  length of the packet being or last drained
busy  output  1  high in any state other than IDLE
err_len  output  1  1-cycle pulse: LEN=0 or LEN>MAX_LEN
err_chk  output  1  1-cycle pulse: checksum mismatch
err_ovr  output  1  1-cycle pulse: byte arrived during DRAIN and was dropped
err_to  output  1  1-cycle pulse: inter-byte timeout

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0. Pointers, length and checksum registers 0. Buffer contents are not reset.
- Checksum: 8-bit XOR of the LEN byte and every payload byte.
- State IDLE:
  - rx_valid && rx_data==SYNC_BYTE -> LEN.
  - All other bytes are ignored silently, with no error.
- State LEN, on rx_valid:
  - rx_data==0 or rx_data>MAX_LEN: pulse err_len, -> IDLE.
  - Otherwise: len<=rx_data, chk<=rx_data, wr_ptr<=0, -> PAYLOAD.
- State PAYLOAD, on rx_valid:
  - buf[wr_ptr]<=rx_data, chk<=chk^rx_data, wr_ptr++.
  - When the byte is written with wr_ptr==len-1, -> CHK.
- State CHK, on rx_valid:
  - rx_data==chk: pkt_len<=len, rd_ptr<=0, -> DRAIN.
  - Otherwise: pulse err_chk, -> IDLE.
  - A SYNC_BYTE value received here is treated as a checksum byte, not as a resync.
- State DRAIN:
  - out_valid=1, out_data=buf[rd_ptr], out_last=(rd_ptr==pkt_len-1).
  - On handshake: rd_ptr++. If out_last, -> IDLE.
  - out_data and out_last hold stable while out_valid && !out_ready.
- Latency: out_valid rises the cycle after the clk edge that samples a correct CHK byte. With out_ready held high, one byte is delivered per cycle.
- Overrun: rx_valid in DRAIN drops the byte and pulses err_ovr the following cycle. This includes a byte coinciding with the final handshake, since state is still DRAIN in that cycle.
- pkt_len holds its value until the next entry to DRAIN.
- Error pulses: registered, high for exactly one cycle, mutually exclusive per event.
- Bytes are never lost outside DRAIN: back-to-back rx_valid on consecutive cycles is supported in every state.

Optional Feature:
Macro UART_PKT_TIMEOUT_EN.
- Defined:
  - An idle counter clears on every rx_valid and on entry to LEN.
  - It counts in LEN, PAYLOAD and CHK.
  - On reaching TIMEOUT_CYC-1 with no rx_valid, the block pulses err_to and returns to IDLE.
  - The counter is held at 0 in IDLE and DRAIN.
- Not defined: no counter logic is built, err_to is tied 0, and a partial packet waits indefinitely.

Test Plan:
1. Bytes 37,A5,03,11,22,33,03 with out_ready=1 -> 37 ignored. out_data sequence 11,22,33 on consecutive cycles. out_last only with 33. pkt_len=3. No error pulses. busy returns to 0 after the last handshake.
2. Bytes A5,02,AA,55,00 (expected CHK=FD) -> err_chk pulses once, out_valid never asserts. The follow-up packet A5,01,7E,7F delivers 7E with out_last=1.
3. A5,00 then A5,11 (MAX_LEN=16) -> two err_len pulses, state IDLE after each. A subsequent A5,10 packet with 16 bytes and a correct CHK delivers all 16, with out_last on the 16th.
4. Good 3-byte packet with out_ready=0 for 5 cycles -> out_data=first byte held stable. A byte strobed during that window raises err_ovr for 1 cycle. Releasing out_ready drains all 3 bytes intact.
5. With UART_PKT_TIMEOUT_EN defined: A5,02,10 then silence for TIMEOUT_CYC cycles -> err_to pulses, busy=0. Without the macro: the same stimulus followed by 20 and checksum 32 after 5000 idle cycles delivers 10,20.
6. Assert reset low mid-PAYLOAD of a 4-byte packet -> all outputs 0 immediately. After release, a fresh packet A5,01,5A,5B delivers 5A with pkt_len=1.
